// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared types and address helper for the HUB75 framebuffer write path
package hub75_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_ADDR,
        ST_BURST,
        ST_BURST_END,
        ST_FLUSH,
        ST_DONE
    } wr_state_t;

    localparam int RGB_R_W = 5;
    localparam int RGB_G_W = 6;
    localparam int RGB_B_W = 5;
    localparam int PX_W    = RGB_R_W + RGB_G_W + RGB_B_W;

    // Pixel offset of a framebuffer location: {frame, line, column-in-pixels}.
    function automatic logic [23:0] fb_offset(input logic [23:0] frame,
                                              input logic [23:0] line,
                                              input logic [23:0] col_px,
                                              input int          col_bits,
                                              input int          line_bits);
        return (frame << (line_bits + col_bits)) | (line << col_bits) | col_px;
    endfunction

endpackage

// File: rtl/hub75_fb_wfifo.sv
// rtl/hub75_fb_wfifo.sv - first-word-fall-through word FIFO with occupancy count
module hub75_fb_wfifo #(
    parameter int DEPTH = 32,
    parameter int W     = 32
) (
    input  logic                     clk_2x,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & (count_q != '0);
    // Empty FIFO presents zero so the head never shows stale storage.
    assign dout    = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
    assign count   = count_q;

    // Storage write; contents need no reset because count gates the head.
    always_ff @(posedge clk_2x) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointer and occupancy tracking; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk_2x) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/hub75_fb_writer.sv
// rtl/hub75_fb_writer.sv - line write DMA: packs RGB565 pixel pairs and bursts them to QPI memory
module hub75_fb_writer
    import hub75_pkg::*;
#(
    parameter int N_FB        = 2,
    parameter int N_BANKS     = 2,
    parameter int N_ROWS      = 32,
    parameter int N_COLS      = 64,
    parameter int BURST_WORDS = 16,
    parameter int FIFO_WORDS  = 32
) (
    input  logic                                        clk_2x,
    input  logic                                        rst,
    input  logic [$clog2(N_FB)-1:0]                     wr_frame_addr,
    input  logic [$clog2(N_BANKS)+$clog2(N_ROWS)-1:0]   wr_line_addr,
    input  logic                                        wr_start,
    output logic                                        wr_busy,
    output logic                                        wr_done,
    input  logic [PX_W-1:0]                             px_data,
    input  logic                                        px_valid,
    output logic                                        px_ready,
    output logic [23:0]                                 fb_addr,
    output logic [31:0]                                 fb_wdata,
    output logic                                        fb_do_write,
    input  logic                                        fb_next_word,
    input  logic                                        fb_is_idle,
    input  logic [23:0]                                 fb_base
);
    localparam int FR_W  = $clog2(N_FB);
    localparam int LN_W  = $clog2(N_BANKS) + $clog2(N_ROWS);
    localparam int COL_W = $clog2(N_COLS);
    localparam int FC_W  = $clog2(FIFO_WORDS) + 1;

    wr_state_t         state_q;
    logic [FR_W-1:0]   frame_q;
    logic [LN_W-1:0]   line_q;
    logic [7:0]        pix_left_q;
    logic [6:0]        words_left_q;
    logic [6:0]        col_word_q;
    logic [FC_W-1:0]   burst_cnt_q;
    logic [23:0]       fb_addr_q;
    logic [15:0]       lo_px_q;
    logic              odd_q;

    logic [FC_W-1:0]   burst_len;
    logic [FC_W-1:0]   fifo_count;
    logic              fifo_full;
    logic              px_accept;
    logic              fifo_push;
    logic              fifo_pop;

    assign burst_len   = (words_left_q >= 7'(BURST_WORDS)) ? FC_W'(BURST_WORDS)
                                                           : FC_W'(words_left_q);
    assign wr_busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign wr_done     = (state_q == ST_DONE);
    assign fb_do_write = (state_q == ST_BURST);
    assign fb_addr     = fb_addr_q;
    assign px_ready    = wr_busy && (pix_left_q != '0) && !fifo_full;
    assign px_accept   = px_valid & px_ready;
    assign fifo_push   = px_accept & odd_q;
    // Controller strobes outside a burst are dropped here, never popping the FIFO.
    assign fifo_pop    = fb_do_write & fb_next_word;

    hub75_fb_wfifo #(
        .DEPTH (FIFO_WORDS),
        .W     (32)
    ) u_wfifo (
        .clk_2x (clk_2x),
        .rst    (rst),
        .push   (fifo_push),
        .din    ({px_data, lo_px_q}),
        .pop    (fifo_pop),
        .dout   (fb_wdata),
        .count  (fifo_count),
        .full   (fifo_full)
    );

    // Line sequencing: wait for a full burst in the FIFO, issue it, repeat, then drain and signal done.
    always_ff @(posedge clk_2x) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            frame_q      <= '0;
            line_q       <= '0;
            pix_left_q   <= '0;
            words_left_q <= '0;
            col_word_q   <= '0;
            burst_cnt_q  <= '0;
            fb_addr_q    <= '0;
        end else begin
            if (px_accept) pix_left_q <= pix_left_q - 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (wr_start) begin
                        frame_q      <= wr_frame_addr;
                        line_q       <= wr_line_addr;
                        pix_left_q   <= 8'(N_COLS);
                        words_left_q <= 7'(N_COLS / 2);
                        col_word_q   <= '0;
                        state_q      <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if ((fifo_count >= burst_len) && fb_is_idle) state_q <= ST_ADDR;
                end
                ST_ADDR: begin
                    fb_addr_q   <= fb_base + fb_offset(24'(frame_q), 24'(line_q),
                                                       24'({col_word_q, 1'b0}), COL_W, LN_W);
                    burst_cnt_q <= burst_len;
                    state_q     <= ST_BURST;
                end
                ST_BURST: begin
                    if (fb_next_word) begin
                        burst_cnt_q  <= burst_cnt_q - 1'b1;
                        words_left_q <= words_left_q - 1'b1;
                        col_word_q   <= col_word_q + 1'b1;
                        if (burst_cnt_q == FC_W'(1)) state_q <= ST_BURST_END;
                    end
                end
                ST_BURST_END: state_q <= (words_left_q != '0) ? ST_FILL : ST_FLUSH;
                ST_FLUSH:     if (fb_is_idle) state_q <= ST_DONE;
                ST_DONE:      state_q <= ST_IDLE;
                default:      state_q <= ST_IDLE;
            endcase
        end
    end

    // Pixel pairing: hold the even pixel until its odd partner completes the word.
    always_ff @(posedge clk_2x) begin
        if (rst) begin
            odd_q   <= 1'b0;
            lo_px_q <= '0;
        end else if (state_q == ST_IDLE) begin
            odd_q   <= 1'b0;
        end else if (px_accept) begin
            if (!odd_q) lo_px_q <= px_data;
            odd_q <= ~odd_q;
        end
    end

endmodule

// File: tb/tb_hub75_fb_writer.sv
// tb/tb_hub75_fb_writer.sv - self-checking bench for hub75_fb_writer
module tb_hub75_fb_writer;

    logic        clk_2x = 1'b0;
    logic        rst;
    logic [0:0]  wr_frame_addr;
    logic [5:0]  wr_line_addr;
    logic        wr_start;
    logic [15:0] px_data;
    logic        px_valid;
    logic        fb_next_word;
    logic        fb_is_idle;
    logic [23:0] fb_base;
    logic        sel;

    logic        a_busy, a_done, a_ready, a_dw;
    logic [23:0] a_addr;
    logic [31:0] a_wdata;
    logic        b_busy, b_done, b_ready, b_dw;
    logic [23:0] b_addr;
    logic [31:0] b_wdata;

    logic        o_wr_busy, o_wr_done, o_px_ready, o_fb_do_write;
    logic [23:0] o_fb_addr;
    logic [31:0] o_fb_wdata;

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] px_mem [0:127];
    logic [31:0] wq     [0:127];
    logic [23:0] baddr  [0:7];
    int          blen   [0:7];
    int          nw, nb, done_cnt, acc_cnt, extra_acc;
    bit          timeout;

    always #5 clk_2x = ~clk_2x;

    hub75_fb_writer dut_a (
        .clk_2x(clk_2x), .rst(rst), .wr_frame_addr(wr_frame_addr), .wr_line_addr(wr_line_addr),
        .wr_start(wr_start & ~sel), .wr_busy(a_busy), .wr_done(a_done), .px_data(px_data),
        .px_valid(px_valid), .px_ready(a_ready), .fb_addr(a_addr), .fb_wdata(a_wdata),
        .fb_do_write(a_dw), .fb_next_word(fb_next_word), .fb_is_idle(fb_is_idle), .fb_base(fb_base)
    );

    hub75_fb_writer #(.N_COLS(40)) dut_b (
        .clk_2x(clk_2x), .rst(rst), .wr_frame_addr(wr_frame_addr), .wr_line_addr(wr_line_addr),
        .wr_start(wr_start & sel), .wr_busy(b_busy), .wr_done(b_done), .px_data(px_data),
        .px_valid(px_valid), .px_ready(b_ready), .fb_addr(b_addr), .fb_wdata(b_wdata),
        .fb_do_write(b_dw), .fb_next_word(fb_next_word), .fb_is_idle(fb_is_idle), .fb_base(fb_base)
    );

    assign o_wr_busy     = sel ? b_busy  : a_busy;
    assign o_wr_done     = sel ? b_done  : a_done;
    assign o_px_ready    = sel ? b_ready : a_ready;
    assign o_fb_do_write = sel ? b_dw    : a_dw;
    assign o_fb_addr     = sel ? b_addr  : a_addr;
    assign o_fb_wdata    = sel ? b_wdata : a_wdata;

    // Runs one line write on the selected DUT and records bursts, words and done pulses.
    task automatic do_line(input logic fr, input logic [5:0] ln, input int npx, input int px_gap,
                           input int nw_gap, input int idle_low, input bit dbl_start, input int seed);
        nw = 0; nb = 0; done_cnt = 0; acc_cnt = 0; extra_acc = 0; timeout = 0;
        for (int i = 0; i < 128; i++) px_mem[i] = 16'(seed * 97 + i * 13 + 1);
        @(negedge clk_2x);
        wr_frame_addr = fr; wr_line_addr = ln; wr_start = 1'b1;
        fb_is_idle = (idle_low == 0);
        @(negedge clk_2x);
        wr_start = 1'b0;
        fork
            begin
                for (int c = 0; c < 3000 && acc_cnt < npx; c++) begin
                    px_valid = ($urandom_range(99) >= px_gap);
                    px_data  = px_mem[acc_cnt];
                    if (dbl_start && c == 5) begin
                        wr_frame_addr = ~fr; wr_line_addr = ~ln; wr_start = 1'b1;
                    end else begin
                        wr_start = 1'b0;
                    end
                    #1;
                    if (px_valid && o_px_ready) acc_cnt++;
                    @(negedge clk_2x);
                end
                wr_start = 1'b0;
                px_valid = 1'b1;
                px_data  = 16'hDEAD;
                for (int c = 0; c < 6; c++) begin
                    #1;
                    if (o_px_ready) extra_acc++;
                    @(negedge clk_2x);
                end
                px_valid = 1'b0;
            end
            begin
                bit prev_dw;
                int post;
                prev_dw = 1'b0;
                post = 0;
                timeout = 1'b1;
                for (int cyc = 0; cyc < 3000; cyc++) begin
                    fb_is_idle = (cyc >= idle_low);
                    if (o_wr_done) done_cnt++;
                    if (o_fb_do_write && !prev_dw && nb < 8) begin
                        baddr[nb] = o_fb_addr;
                        blen[nb]  = 0;
                        nb++;
                    end
                    prev_dw = o_fb_do_write;
                    fb_next_word = o_fb_do_write && ($urandom_range(99) >= nw_gap);
                    if (fb_next_word && nw < 128) begin
                        wq[nw] = o_fb_wdata;
                        nw++;
                        if (nb > 0) blen[nb-1]++;
                    end
                    if (done_cnt > 0) post++;
                    @(negedge clk_2x);
                    if (post > 5) begin
                        timeout = 1'b0;
                        break;
                    end
                end
                fb_next_word = 1'b0;
            end
        join
        px_valid = 1'b0;
        fb_next_word = 1'b0;
        fb_is_idle = 1'b1;
    endtask

    task automatic test_reset;
        sel = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk_2x);
        n_chk++; if (o_wr_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", o_wr_busy); end
        n_chk++; if (o_wr_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", o_wr_done); end
        n_chk++; if (o_px_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b expected 0", o_px_ready); end
        n_chk++; if (o_fb_do_write !== 1'b0) begin n_err++; $display("FAIL reset_do_write: got %b expected 0", o_fb_do_write); end
        n_chk++; if (o_fb_addr !== 24'h0) begin n_err++; $display("FAIL reset_addr: got %h expected 000000", o_fb_addr); end
        n_chk++; if (o_fb_wdata !== 32'h0) begin n_err++; $display("FAIL reset_wdata: got %h expected 00000000", o_fb_wdata); end
        rst = 1'b0;
        @(negedge clk_2x);
    endtask

    task automatic test_full_line;
        sel = 1'b0;
        fb_base = 24'h000400;
        do_line(1'b0, 6'd3, 64, 0, 0, 0, 1'b0, 1);
        n_chk++; if (timeout) begin n_err++; $display("FAIL full_timeout: got timeout expected wr_done"); end
        n_chk++; if (nb !== 2) begin n_err++; $display("FAIL full_bursts: got %0d expected 2", nb); end
        n_chk++; if (baddr[0] !== 24'h0004C0) begin n_err++; $display("FAIL full_addr0: got %h expected 0004c0", baddr[0]); end
        n_chk++; if (baddr[1] !== 24'h0004E0) begin n_err++; $display("FAIL full_addr1: got %h expected 0004e0", baddr[1]); end
        n_chk++; if (blen[0] !== 16 || blen[1] !== 16) begin n_err++; $display("FAIL full_len: got %0d,%0d expected 16,16", blen[0], blen[1]); end
        n_chk++; if (nw !== 32) begin n_err++; $display("FAIL full_words: got %0d expected 32", nw); end
        for (int k = 0; k < nw && k < 32; k++) begin
            n_chk++;
            if (wq[k] !== {px_mem[2*k+1], px_mem[2*k]}) begin
                n_err++; $display("FAIL full_word%0d: got %h expected %h", k, wq[k], {px_mem[2*k+1], px_mem[2*k]});
            end
        end
        n_chk++; if (done_cnt !== 1) begin n_err++; $display("FAIL full_done: got %0d expected 1", done_cnt); end
        n_chk++; if (extra_acc !== 0) begin n_err++; $display("FAIL full_extra_px: got %0d expected 0", extra_acc); end
        n_chk++; if (o_wr_busy !== 1'b0) begin n_err++; $display("FAIL full_busy_after: got %b expected 0", o_wr_busy); end
    endtask

    task automatic test_addr;
        sel = 1'b0;
        fb_base = 24'h100000;
        do_line(1'b1, 6'd5, 64, 0, 0, 0, 1'b0, 2);
        n_chk++; if (baddr[0] !== 24'h101140) begin n_err++; $display("FAIL addr_frame1: got %h expected 101140", baddr[0]); end
        n_chk++; if (baddr[1] !== 24'h101160) begin n_err++; $display("FAIL addr_frame1_b2: got %h expected 101160", baddr[1]); end
        fb_base = 24'hFFFFF0;
        do_line(1'b1, 6'd63, 64, 0, 0, 0, 1'b0, 3);
        n_chk++; if (baddr[0] !== 24'h001FB0) begin n_err++; $display("FAIL addr_wrap0: got %h expected 001fb0", baddr[0]); end
        n_chk++; if (baddr[1] !== 24'h001FD0) begin n_err++; $display("FAIL addr_wrap1: got %h expected 001fd0", baddr[1]); end
        n_chk++; if (done_cnt !== 1) begin n_err++; $display("FAIL addr_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_short_line;
        sel = 1'b1;
        fb_base = 24'h000000;
        do_line(1'b0, 6'd1, 40, 0, 0, 0, 1'b0, 4);
        n_chk++; if (nb !== 2) begin n_err++; $display("FAIL short_bursts: got %0d expected 2", nb); end
        n_chk++; if (blen[0] !== 16 || blen[1] !== 4) begin n_err++; $display("FAIL short_len: got %0d,%0d expected 16,4", blen[0], blen[1]); end
        n_chk++; if (baddr[0] !== 24'h000040 || baddr[1] !== 24'h000060) begin n_err++; $display("FAIL short_addr: got %h,%h expected 000040,000060", baddr[0], baddr[1]); end
        n_chk++; if (acc_cnt !== 40) begin n_err++; $display("FAIL short_accepted: got %0d expected 40", acc_cnt); end
        n_chk++; if (extra_acc !== 0) begin n_err++; $display("FAIL short_extra_px: got %0d expected 0", extra_acc); end
        n_chk++; if (nw !== 20) begin n_err++; $display("FAIL short_words: got %0d expected 20", nw); end
        for (int k = 0; k < nw && k < 20; k++) begin
            n_chk++;
            if (wq[k] !== {px_mem[2*k+1], px_mem[2*k]}) begin
                n_err++; $display("FAIL short_word%0d: got %h expected %h", k, wq[k], {px_mem[2*k+1], px_mem[2*k]});
            end
        end
        n_chk++; if (done_cnt !== 1) begin n_err++; $display("FAIL short_done: got %0d expected 1", done_cnt); end
        sel = 1'b0;
    endtask

    task automatic test_gaps;
        sel = 1'b0;
        fb_base = 24'h020000;
        do_line(1'b0, 6'd10, 64, 0, 50, 10, 1'b0, 5);
        n_chk++; if (timeout) begin n_err++; $display("FAIL gaps_timeout: got timeout expected wr_done"); end
        n_chk++; if (nw !== 32) begin n_err++; $display("FAIL gaps_words: got %0d expected 32", nw); end
        for (int k = 0; k < nw && k < 32; k++) begin
            n_chk++;
            if (wq[k] !== {px_mem[2*k+1], px_mem[2*k]}) begin
                n_err++; $display("FAIL gaps_word%0d: got %h expected %h", k, wq[k], {px_mem[2*k+1], px_mem[2*k]});
            end
        end
        n_chk++; if (baddr[0] !== 24'h020280) begin n_err++; $display("FAIL gaps_addr: got %h expected 020280", baddr[0]); end
        n_chk++; if (done_cnt !== 1) begin n_err++; $display("FAIL gaps_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_sparse_restart;
        sel = 1'b0;
        fb_base = 24'h000000;
        do_line(1'b1, 6'd2, 64, 60, 20, 0, 1'b1, 6);
        n_chk++; if (baddr[0] !== 24'h001080) begin n_err++; $display("FAIL sparse_addr: got %h expected 001080", baddr[0]); end
        n_chk++; if (nw !== 32) begin n_err++; $display("FAIL sparse_words: got %0d expected 32", nw); end
        for (int k = 0; k < nw && k < 32; k++) begin
            n_chk++;
            if (wq[k] !== {px_mem[2*k+1], px_mem[2*k]}) begin
                n_err++; $display("FAIL sparse_word%0d: got %h expected %h", k, wq[k], {px_mem[2*k+1], px_mem[2*k]});
            end
        end
        n_chk++; if (done_cnt !== 1) begin n_err++; $display("FAIL sparse_done: got %0d expected 1", done_cnt); end
        n_chk++; if (o_wr_busy !== 1'b0) begin n_err++; $display("FAIL sparse_busy_after: got %b expected 0", o_wr_busy); end
    endtask

    task automatic test_reset_mid_burst;
        int taken;
        sel = 1'b0;
        fb_base = 24'h000200;
        taken = 0;
        @(negedge clk_2x);
        wr_frame_addr = 1'b0; wr_line_addr = 6'd7; wr_start = 1'b1;
        @(negedge clk_2x);
        wr_start = 1'b0;
        for (int c = 0; c < 200 && taken < 3; c++) begin
            px_valid = 1'b1;
            px_data  = 16'(c);
            fb_next_word = o_fb_do_write;
            if (o_fb_do_write) taken++;
            @(negedge clk_2x);
        end
        fb_next_word = 1'b0;
        px_valid = 1'b0;
        n_chk++; if (taken !== 3) begin n_err++; $display("FAIL rstmid_reach_burst: got %0d words expected 3", taken); end
        n_chk++; if (o_fb_do_write !== 1'b1) begin n_err++; $display("FAIL rstmid_in_burst: got %b expected 1", o_fb_do_write); end
        rst = 1'b1;
        @(negedge clk_2x);
        n_chk++; if (o_fb_do_write !== 1'b0) begin n_err++; $display("FAIL rstmid_do_write: got %b expected 0", o_fb_do_write); end
        n_chk++; if (o_wr_busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b expected 0", o_wr_busy); end
        n_chk++; if (o_fb_wdata !== 32'h0) begin n_err++; $display("FAIL rstmid_fifo_cleared: got %h expected 00000000", o_fb_wdata); end
        rst = 1'b0;
        @(negedge clk_2x);
        do_line(1'b0, 6'd7, 64, 0, 0, 0, 1'b0, 7);
        n_chk++; if (baddr[0] !== 24'h0003C0) begin n_err++; $display("FAIL rstmid_clean_addr: got %h expected 0003c0", baddr[0]); end
        n_chk++; if (nw !== 32) begin n_err++; $display("FAIL rstmid_clean_words: got %0d expected 32", nw); end
        for (int k = 0; k < nw && k < 32; k++) begin
            n_chk++;
            if (wq[k] !== {px_mem[2*k+1], px_mem[2*k]}) begin
                n_err++; $display("FAIL rstmid_word%0d: got %h expected %h", k, wq[k], {px_mem[2*k+1], px_mem[2*k]});
            end
        end
        n_chk++; if (done_cnt !== 1) begin n_err++; $display("FAIL rstmid_clean_done: got %0d expected 1", done_cnt); end
    endtask

    initial begin
        rst = 1'b1;
        sel = 1'b0;
        wr_frame_addr = '0;
        wr_line_addr = '0;
        wr_start = 1'b0;
        px_data = '0;
        px_valid = 1'b0;
        fb_next_word = 1'b0;
        fb_is_idle = 1'b1;
        fb_base = '0;
        test_reset;
        test_full_line;
        test_addr;
        test_short_line;
        test_gaps;
        test_sparse_restart;
        test_reset_mid_burst;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
